// File: rtl/gpr_file_sb.sv
// Multi-port GPR file with write-back scoreboard: async reads, priority-resolved writes, busy tracking.
// Optional same-cycle write forwarding enabled by defining GPR_BYPASS_EN.
`timescale 1ns/1ps
module gpr_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]        iss_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] iss_addr_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          busy_cnt_o
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   reg_data [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] data_reg, data_next;
            logic              busy_reg, busy_next;
            logic              wr_hit, iss_hit;

            // Later write ports overwrite earlier ones, so the highest index wins a collision.
            always_comb begin
                data_next = data_reg;
                busy_next = busy_reg;
                wr_hit    = 1'b0;
                iss_hit   = 1'b0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] && wr_addr_i[j*ADDR_W +: ADDR_W] == ADDR_W'(gi)) begin
                        data_next = wr_data_i[j*DATA_W +: DATA_W];
                        wr_hit    = 1'b1;
                    end
                    if (iss_en_i[j] && iss_addr_i[j*ADDR_W +: ADDR_W] == ADDR_W'(gi))
                        iss_hit = 1'b1;
                end
                if (flush_i)
                    busy_next = 1'b0;
                else if (iss_hit)
                    busy_next = 1'b1;
                else if (wr_hit)
                    busy_next = 1'b0;
                if (gi == 0) begin
                    data_next = '0;
                    busy_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                    busy_reg <= 1'b0;
                end else begin
                    data_reg <= data_next;
                    busy_reg <= busy_next;
                end
            end

            assign reg_data[gi] = data_reg;
            assign busy_vec[gi] = busy_reg;
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data_next;
            logic              busy_next;
            assign addr = rd_addr_i[gi*ADDR_W +: ADDR_W];

            always_comb begin
                data_next = reg_data[addr];
                busy_next = busy_vec[addr];
`ifdef GPR_BYPASS_EN
                // A matching write retires the producer, unless a new producer issues to it now.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] && wr_addr_i[j*ADDR_W +: ADDR_W] == addr && addr != '0) begin
                        data_next = wr_data_i[j*DATA_W +: DATA_W];
                        busy_next = 1'b0;
                    end
                end
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] && wr_addr_i[j*ADDR_W +: ADDR_W] == addr && addr != '0) begin
                        for (int m = 0; m < NUM_WR; m++) begin
                            if (iss_en_i[m] && iss_addr_i[m*ADDR_W +: ADDR_W] == addr)
                                busy_next = 1'b1;
                        end
                    end
                end
`endif
            end

            assign rd_data_o[gi*DATA_W +: DATA_W] = data_next;
            assign rd_busy_o[gi]                  = busy_next;
        end
    endgenerate

    always_comb begin
        busy_cnt_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            busy_cnt_o = busy_cnt_o + (ADDR_W+1)'(busy_vec[i]);
    end
endmodule
